// File: rtl/lives_manager_if.sv
// Signal bundle between the game core and the lives manager.
// The game side (master) drives collision/restart_btn; the lives manager (slave) drives the status outputs.
interface lives_manager_if;
  logic       collision;
  logic       restart_btn;
  logic [1:0] lives;
  logic       reset_level;
  logic       frog_hit;
  logic       invulnerable;
  logic       game_over;

  // Level-based, no handshake: every output is a registered status valid every cycle.
  modport master (
    output collision, restart_btn,
    input  lives, reset_level, frog_hit, invulnerable, game_over
  );

  modport slave (
    input  collision, restart_btn,
    output lives, reset_level, frog_hit, invulnerable, game_over
  );
endinterface

// File: rtl/lives_manager.sv
// Frog lives bookkeeping: hit handling, post-hit invulnerability window,
// game-over hold and a one-cycle restart that asks the level counter to reset.
module lives_manager #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_CYCLES = 25_000_000
) (
  input  logic           clk,
  input  logic           reset,
  lives_manager_if.slave bus,
  output logic [1:0]     dbg_state
);

  localparam int TW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(INVULN_CYCLES - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(MAX_LIVES);

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2,
    RESTART   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    lives_q, lives_d;
  logic          btn_prev_q;
  logic          frog_hit_q, frog_hit_d;
  logic          reset_level_q, reset_level_d;
  logic          invuln_q, invuln_d;
  logic          game_over_q, game_over_d;
  logic          btn_rise;

  // Previous sample resets to 1 so a button held across reset is not seen as a press.
  assign btn_rise = bus.restart_btn & ~btn_prev_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    lives_d    = lives_q;
    frog_hit_d = 1'b0;
    case (state_q)
      PLAY: begin
        if (bus.collision) begin
          frog_hit_d = 1'b1;
          if (lives_q > 2'd1) begin
            lives_d = lives_q - 2'd1;
            timer_d = TIMER_LOAD;
            state_d = INVULN;
          end else begin
            lives_d = 2'd0;
            state_d = GAME_OVER;
          end
        end
      end
      INVULN: begin
        if (timer_q == '0) state_d = PLAY;
        else               timer_d = timer_q - TW'(1);
      end
      GAME_OVER: begin
        lives_d = 2'd0;
        if (btn_rise) state_d = RESTART;
      end
      RESTART: begin
        lives_d = LIVES_INIT;
        state_d = PLAY;
      end
      default: state_d = PLAY;
    endcase
    // Status outputs are registered copies of what the next state implies.
    invuln_d      = (state_d == INVULN);
    game_over_d   = (state_d == GAME_OVER) || (state_d == RESTART);
    reset_level_d = (state_d == RESTART);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PLAY;
      timer_q       <= '0;
      lives_q       <= LIVES_INIT;
      btn_prev_q    <= 1'b1;
      frog_hit_q    <= 1'b0;
      reset_level_q <= 1'b0;
      invuln_q      <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      lives_q       <= lives_d;
      btn_prev_q    <= bus.restart_btn;
      frog_hit_q    <= frog_hit_d;
      reset_level_q <= reset_level_d;
      invuln_q      <= invuln_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.lives        = lives_q;
  assign bus.frog_hit     = frog_hit_q;
  assign bus.reset_level  = reset_level_q;
  assign bus.invulnerable = invuln_q;
  assign bus.game_over    = game_over_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lives_manager.sv
// Randomized and directed bench for lives_manager; a counting reference model
// predicts every cycle's outputs, a monitor compares them against the DUT.
module tb_lives_manager;

  localparam int MAX_LIVES     = 3;
  localparam int INVULN_CYCLES = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  lives_manager_if bus ();

  lives_manager #(
    .MAX_LIVES    (MAX_LIVES),
    .INVULN_CYCLES(INVULN_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // scoreboard: {lives[1:0], reset_level, frog_hit, invulnerable, game_over}
  logic [5:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  // reference model: plain counters of lives and remaining invulnerable cycles
  int m_lives;
  int m_inv_left;
  bit m_over;
  bit m_restart;
  bit m_prev_btn;

  task automatic model_step(input bit rst, input bit coll, input bit btn);
    bit hit;
    hit = 1'b0;
    if (rst) begin
      m_lives    = MAX_LIVES;
      m_inv_left = 0;
      m_over     = 1'b0;
      m_restart  = 1'b0;
      m_prev_btn = 1'b1;
    end else begin
      if (m_restart) begin
        m_restart = 1'b0;
        m_over    = 1'b0;
        m_lives   = MAX_LIVES;
      end else if (m_over) begin
        if (btn && !m_prev_btn) m_restart = 1'b1;
      end else if (m_inv_left > 0) begin
        m_inv_left--;
      end else if (coll) begin
        hit = 1'b1;
        if (m_lives > 1) begin
          m_lives--;
          m_inv_left = INVULN_CYCLES;
        end else begin
          m_lives = 0;
          m_over  = 1'b1;
        end
      end
      m_prev_btn = btn;
    end
    exp_q.push_back({2'(m_lives), m_restart, hit, (m_inv_left > 0), m_over});
  endtask

  // driver: one call = one clock cycle of stimulus
  task automatic step(input bit rst, input bit coll, input bit btn);
    @(negedge clk);
    reset           = rst;
    bus.collision   = coll;
    bus.restart_btn = btn;
    model_step(rst, coll, btn);
  endtask

  task automatic idle(input int n, input bit btn);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, btn);
  endtask

  // monitor: compares the DUT outputs against the queue after every edge
  logic [5:0] got;
  logic [5:0] exp_v;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got   = {bus.lives, bus.reset_level, bus.frog_hit, bus.invulnerable, bus.game_over};
        checks++;
        if (got !== exp_v) begin
          failures++;
          $display("FAIL outputs cycle=%0d got lives=%0d rl=%0b hit=%0b inv=%0b go=%0b exp lives=%0d rl=%0b hit=%0b inv=%0b go=%0b",
                   cycle_no, got[5:4], got[3], got[2], got[1], got[0],
                   exp_v[5:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
        checks++;
        if (bus.frog_hit === 1'b1 && bus.reset_level === 1'b1) begin
          failures++;
          $display("FAIL pulse_overlap cycle=%0d got frog_hit=1 reset_level=1 exp not both", cycle_no);
        end
      end
    end
  end

  initial begin
    reset           = 1'b1;
    bus.collision   = 1'b0;
    bus.restart_btn = 1'b0;

    // reset, single collision, full invulnerability window
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(8, 1'b0);

    // collision held 20 cycles from 3 lives; button rises before game over
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, (i >= 8));
    idle(5, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);

    // button pulses in PLAY and INVULN are ignored
    step(1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(6, 1'b0);

    // reset on the 2nd INVULN cycle, then a fresh collision
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(6, 1'b0);

    // reset during the RESTART cycle
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    idle(4, 1'b0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 25));
    end
    idle(3, 1'b0);

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lives_manager.md
LIVES_MANAGER -- requirements
Module: lives_manager

Interface
REQ-001 SHALL provide parameter MAX_LIVES, default 3, the lives count at reset and restart (legal range 1..3).
REQ-002 SHALL provide parameter INVULN_CYCLES, default 25_000_000, the post-hit invulnerability length in clk cycles (1 s at 25 MHz; minimum 1).
REQ-003 SHALL provide port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high block reset.
REQ-005 SHALL provide port collision  input  1  level; the frog overlaps a hazard this cycle.
REQ-006 SHALL provide port restart_btn  input  1  debounced level of the restart button.
REQ-007 SHALL provide port lives  output  2  remaining lives, consumed by the level counter.
REQ-008 SHALL provide port reset_level  output  1  one-cycle pulse requesting a level reset.
REQ-009 SHALL provide port frog_hit  output  1  one-cycle pulse requesting a frog respawn at bottom centre.
REQ-010 SHALL provide port invulnerable  output  1  high while collisions are ignored.
REQ-011 SHALL provide port game_over  output  1  high while no lives remain.

Function
REQ-012 SHALL implement a registered FSM with the states PLAY, INVULN, GAME_OVER and RESTART.
REQ-013 SHALL register all outputs, with the FSM's state updates visible on the outputs one cycle after the triggering input is sampled.
REQ-014 In PLAY with collision=1 and lives>1, the block SHALL decrement lives by 1, pulse frog_hit for 1 cycle, load the timer with INVULN_CYCLES-1 and enter INVULN.
REQ-015 In PLAY with collision=1 and lives==1, the block SHALL set lives=0, pulse frog_hit for 1 cycle and enter GAME_OVER.
REQ-016 In INVULN, the block SHALL hold invulnerable=1, ignore collision and decrement the timer each cycle, then return to PLAY on the cycle after the timer reads 0 (invulnerable high for exactly INVULN_CYCLES cycles).
REQ-017 In GAME_OVER, the block SHALL hold game_over=1 and lives=0, and SHALL ignore collision.
REQ-018 In GAME_OVER, a rising edge of restart_btn (current=1, previous registered sample=0) SHALL move the FSM to RESTART.
REQ-019 RESTART SHALL last exactly 1 cycle, with reset_level=1, lives=0 and game_over=1, so the downstream level counter sees reset_level with lives==0.
REQ-020 On leaving RESTART, the block SHALL set lives=MAX_LIVES, game_over=0, reset_level=0 and enter PLAY.
REQ-021 restart_btn SHALL have no effect in PLAY or INVULN, and a button held through GAME_OVER entry SHALL NOT trigger a restart until released and pressed again.
REQ-022 frog_hit and reset_level SHALL never be high in the same cycle, and neither SHALL exceed 1 cycle.
REQ-023 A collision held high continuously SHALL cost exactly one life per entry into PLAY.
REQ-024 lives SHALL saturate at 0, with no wrap below 0.
REQ-025 The timer SHALL be sized to hold INVULN_CYCLES-1 (25 bits at the default).

Reset
REQ-026 When reset=1 at a clk edge, the block SHALL enter PLAY with lives=MAX_LIVES, timer=0, the restart_btn previous sample=1, and reset_level=0, frog_hit=0, invulnerable=0, game_over=0.
REQ-027 Reset SHALL override every other input and abort INVULN, GAME_OVER and RESTART mid-operation.

Verification (INVULN_CYCLES=4, MAX_LIVES=3)
REQ-028 The bench SHALL cover: reset, then 1-cycle collision -> lives 3->2, one frog_hit pulse, invulnerable high for exactly 4 cycles, then PLAY.
REQ-029 The bench SHALL cover: collision held high for 20 cycles from PLAY with lives=3 -> lives 2, 1, 0 at 5-cycle spacing, 3 frog_hit pulses, game_over=1.
REQ-030 The bench SHALL cover: GAME_OVER with restart_btn already high -> no restart; release then press -> one reset_level pulse with lives=0, next cycle lives=3, game_over=0.
REQ-031 The bench SHALL cover: restart_btn pulsed in PLAY and in INVULN -> no reset_level pulse, lives unchanged.
REQ-032 The bench SHALL cover: reset asserted on the 2nd INVULN cycle -> next cycle lives=3, invulnerable=0, state PLAY, and the next collision decrements to 2.
REQ-033 The bench SHALL cover: reset asserted during the RESTART cycle -> reset_level=0 next cycle, lives=3.
